// File: rtl/mem_responder_pkg.sv
// Shared definitions for the fixed-latency memory responder.
// Defaults are common to the CPU top and the benches.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int CNT_W          = 4;
  localparam int DEF_LATENCY    = 4;
  localparam int DEF_DEPTH_LOG2 = 10;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port 16-bit word storage.
// Synchronous write and clear, combinational read.
module mem_array_sp
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [15:0] mem [0:WORDS-1];

  // Clear every word on reset, otherwise store on write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency request/response memory end of the CPU bus.
// One outstanding request; RESP cycle may accept the next.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] req_addr;
  logic [15:0]           req_data;
  logic                  req_wr;
  logic [15:0]           rdata;
  logic                  mem_we;
  logic                  unused_addr;

  // Bits outside the word index are aliased away
  assign unused_addr = ^{addr[15:DEPTH_LOG2+1], addr[0]};

  // The access happens on the last WAIT edge
  assign mem_we = (state == WAIT) && (cnt == '0) && req_wr;

  mem_array_sp #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .addr (req_addr),
    .wdata(req_data),
    .rdata(rdata)
  );

  // Handshake FSM with latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_wr     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          data_valid <= 1'b0;
          if (enable) begin
            req_addr <= addr[DEPTH_LOG2:1];
            req_data <= data_in;
            req_wr   <= wr;
            cnt      <= CNT_W'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!req_wr) begin
              data_out <= rdata;
            end
            busy       <= 1'b0;
            data_valid <= 1'b1;
            state      <= RESP;
          end
        end
        default: begin
          busy       <= 1'b0;
          data_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// Second instance runs with LATENCY=1.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = DEF_LATENCY;

  typedef struct {
    logic        w;
    logic [15:0] d;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        wr = 1'b0;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [15:0] data_out0, data_out1;
  logic        data_valid0, data_valid1;
  logic        busy0, busy1;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_prev = -100;
  int          pulse_last = -100;
  logic [15:0] last_rd = '0;
  logic [15:0] model [0:1023];
  exp_t        q[$];

  mem_responder dut0 (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .enable    (en0),
    .wr        (wr),
    .data_out  (data_out0),
    .data_valid(data_valid0),
    .busy      (busy0)
  );

  mem_responder #(
    .LATENCY(1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .enable    (en1),
    .wr        (wr),
    .data_out  (data_out1),
    .data_valid(data_valid1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_valid0) begin
      pulse_prev = pulse_last;
      pulse_last = cyc;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got pulse at cycle %0d, want none",
                 cyc);
      end else begin
        e = q.pop_front();
        if (cyc - e.acc != LAT) begin
          miscompares++;
          $display("FAIL latency: got %0d, want %0d", cyc - e.acc, LAT);
        end
        vectors++;
        if (!e.w) begin
          if (data_out0 !== e.d) begin
            miscompares++;
            $display("FAIL read_data: got %h, want %h", data_out0, e.d);
          end
          last_rd = e.d;
        end else if (data_out0 !== last_rd) begin
          miscompares++;
          $display("FAIL write_keeps_dout: got %h, want %h",
                   data_out0, last_rd);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
    q.delete();
    last_rd = '0;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d,
                      input logic w);
    exp_t e;
    e.w   = w;
    e.acc = cyc;
    if (w) begin
      model[a[10:1]] = d;
      e.d = d;
    end else begin
      e.d = model[a[10:1]];
    end
    q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic keep);
    @(negedge clk);
    addr    = a;
    data_in = d;
    wr      = w;
    en0     = 1'b1;
    @(posedge clk);
    #1;
    push(a, d, w);
    if (!keep) en0 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (busy0 !== 1'b0 || data_valid0 !== 1'b0 || data_out0 !== 16'h0)
      begin
        miscompares++;
        $display("FAIL reset_state: got busy=%b dv=%b dout=%h, want 0 0 0",
                 busy0, data_valid0, data_out0);
      end
    end
    rst = 1'b0;
    model_clear();
    issue(16'h0010, 16'h0, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_write_read();
    issue(16'h0020, 16'hBEEF, 1'b1, 1'b0);
    wait_done();
    issue(16'h0020, 16'h0, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_busy_drop();
    issue(16'h0020, 16'h0, 1'b0, 1'b0);
    addr    = 16'h0030;
    data_in = 16'h1234;
    wr      = 1'b1;
    en0     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (busy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_in_wait: got %b, want 1", busy0);
      end
    end
    @(posedge clk);
    #1;
    en0 = 1'b0;
    wait_done();
    issue(16'h0030, 16'h0, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    issue(16'h0040, 16'h0A0A, 1'b1, 1'b0);
    wait_done();
    issue(16'h0042, 16'h0B0B, 1'b1, 1'b0);
    wait_done();
    issue(16'h0040, 16'h0, 1'b0, 1'b1);
    addr = 16'h0042;
    @(negedge clk);
    while (!data_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    push(16'h0042, 16'h0, 1'b0);
    en0 = 1'b0;
    wait_done();
    vectors++;
    if (pulse_last - pulse_prev != 5) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d, want 5", pulse_last - pulse_prev);
    end
  endtask

  task automatic test_reset_mid_write();
    issue(16'h0050, 16'h5555, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (data_valid0 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_drop: got dv=%b, want 0", data_valid0);
      end
    end
    issue(16'h0050, 16'h0, 1'b0, 1'b0);
    wait_done();
  endtask

  task automatic test_lat1_alias();
    @(negedge clk);
    addr    = 16'h0801;
    data_in = 16'h7777;
    wr      = 1'b1;
    en1     = 1'b1;
    @(posedge clk);
    #1;
    en1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy1 !== 1'b1 || data_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL lat1_wait: got busy=%b dv=%b, want 1 0",
               busy1, data_valid1);
    end
    @(negedge clk);
    vectors++;
    if (data_valid1 !== 1'b1) begin
      miscompares++;
      $display("FAIL lat1_wr_valid: got %b, want 1", data_valid1);
    end
    addr = 16'h0000;
    wr   = 1'b0;
    en1  = 1'b1;
    @(posedge clk);
    #1;
    en1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (data_valid1 !== 1'b1 || data_out1 !== 16'h7777) begin
      miscompares++;
      $display("FAIL lat1_alias_rd: got dv=%b dout=%h, want 1 7777",
               data_valid1, data_out1);
    end
    @(negedge clk);
    vectors++;
    if (data_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL lat1_pulse_width: got %b, want 0", data_valid1);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid_write();
    test_lat1_alias();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
